// File: rtl/persist_trigger_if.sv
// Handshake bundle for persist_trigger: clear and raw enables in,
// debounced levels and edge pulses out.
interface persist_trigger_if #(
   parameter int CH = 4
);
   logic          clr;
   logic [CH-1:0] ena;
   logic [CH-1:0] trigger;
   logic [CH-1:0] trig_pulse;
   logic [CH-1:0] rel_pulse;
   logic          any_trigger;

   modport master (
      output clr, ena,
      input  trigger, trig_pulse, rel_pulse, any_trigger
   );

   modport slave (
      input  clr, ena,
      output trigger, trig_pulse, rel_pulse, any_trigger
   );
endinterface

// File: rtl/persist_trigger.sv
// Multi-channel persistence detector with hysteresis and rise/fall pulses.
// Ports: clk, rst_n (sync, active-low), bus (slave: clr, ena in;
// trigger, trig_pulse, rel_pulse, any_trigger out, all registered).
module persist_trigger #(
   parameter int CH      = 4,
   parameter int ON_CNT  = 4,
   parameter int OFF_CNT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   persist_trigger_if.slave bus
);
   localparam int MAXC = (ON_CNT > OFF_CNT) ? ON_CNT : OFF_CNT;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] ON_LAST  = CW'(ON_CNT - 1);
   localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CNT - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   state_e        state_q [CH];
   state_e        state_d [CH];
   logic [CW-1:0] cnt_q   [CH];
   logic [CW-1:0] cnt_d   [CH];
   logic [CH-1:0] act_q;
   logic [CH-1:0] act_d;
   logic [CH-1:0] rise_q;
   logic [CH-1:0] rise_d;
   logic [CH-1:0] fall_q;
   logic [CH-1:0] fall_d;
   logic          any_q;

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         rise_d[i]  = 1'b0;
         fall_d[i]  = 1'b0;
         unique case (state_q[i])
            IDLE: begin
               if (!bus.ena[i]) begin
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == ON_LAST) begin
                  state_d[i] = ACTIVE;
                  cnt_d[i]   = '0;
                  rise_d[i]  = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end
            ACTIVE: begin
               if (bus.ena[i]) begin
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == OFF_LAST) begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
                  fall_d[i]  = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end
            default: begin
               state_d[i] = IDLE;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         act_q[i] = (state_q[i] == ACTIVE);
         act_d[i] = (state_d[i] == ACTIVE);
      end
   end

   // Clear behaves exactly like reset: no release pulse is emitted.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.clr) begin
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
         rise_q <= '0;
         fall_q <= '0;
         any_q  <= 1'b0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         rise_q <= rise_d;
         fall_q <= fall_d;
         any_q  <= |act_d;
      end
   end

   assign bus.trigger     = act_q;
   assign bus.trig_pulse  = rise_q;
   assign bus.rel_pulse   = fall_q;
   assign bus.any_trigger = any_q;
endmodule

// File: tb/tb_persist_trigger.sv
// Bench for persist_trigger: vector table, directed corner sequences
// and random stimulus against a sample-window reference model.
module tb_persist_trigger;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   persist_trigger_if #(.CH(4)) ia ();
   persist_trigger_if #(.CH(4)) ib ();
   persist_trigger_if #(.CH(4)) ic ();

   persist_trigger #(.CH(4), .ON_CNT(4), .OFF_CNT(1)) da (
      .clk(clk), .rst_n(rst_n), .bus(ia));
   persist_trigger #(.CH(4), .ON_CNT(3), .OFF_CNT(3)) db (
      .clk(clk), .rst_n(rst_n), .bus(ib));
   persist_trigger #(.CH(4), .ON_CNT(1), .OFF_CNT(1)) dc (
      .clk(clk), .rst_n(rst_n), .bus(ic));

   // Reference: a channel asserts when the last ON samples since clear
   // are all high, and releases when the last OFF samples are all low.
   logic [3:0]  mtrig [3];
   logic [3:0]  mtp   [3];
   logic [3:0]  mrp   [3];
   logic [15:0] win   [3][4];
   int          nv    [3][4];

   task automatic mstep(input int d, input int on, input int off,
                        input logic rs, input logic [3:0] e);
      logic [15:0] mon;
      logic [15:0] moff;
      logic        p;
      logic        n;
      mon  = 16'((32'd1 << on) - 1);
      moff = 16'((32'd1 << off) - 1);
      if (rs) begin
         mtrig[d] = '0;
         mtp[d]   = '0;
         mrp[d]   = '0;
         for (int c = 0; c < 4; c++) begin
            win[d][c] = '0;
            nv[d][c]  = 0;
         end
      end else begin
         for (int c = 0; c < 4; c++) begin
            win[d][c] = {win[d][c][14:0], e[c]};
            if (nv[d][c] < 16) nv[d][c]++;
            p = mtrig[d][c];
            if (!p)
               n = (nv[d][c] >= on) && ((win[d][c] & mon) == mon);
            else
               n = !((nv[d][c] >= off) && ((win[d][c] & moff) == 16'h0));
            mtrig[d][c] = n;
            mtp[d][c]   = n & !p;
            mrp[d][c]   = p & !n;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [3:0] act,
                      input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chkd(input string nm, input int d, input logic [3:0] t,
                       input logic [3:0] tp, input logic [3:0] rp,
                       input logic an);
      chk({nm, ".trigger"}, t, mtrig[d]);
      chk({nm, ".trig_pulse"}, tp, mtp[d]);
      chk({nm, ".rel_pulse"}, rp, mrp[d]);
      chk({nm, ".any"}, {3'b0, an}, {3'b0, |mtrig[d]});
   endtask

   task automatic tick();
      @(posedge clk);
      mstep(0, 4, 1, !rst_n || ia.clr, ia.ena);
      mstep(1, 3, 3, !rst_n || ib.clr, ib.ena);
      mstep(2, 1, 1, !rst_n || ic.clr, ic.ena);
      #1;
      chkd("modelA", 0, ia.trigger, ia.trig_pulse, ia.rel_pulse,
           ia.any_trigger);
      chkd("modelB", 1, ib.trigger, ib.trig_pulse, ib.rel_pulse,
           ib.any_trigger);
      chkd("modelC", 2, ic.trigger, ic.trig_pulse, ic.rel_pulse,
           ic.any_trigger);
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] ena;
      logic [3:0] trig;
      logic [3:0] tp;
      logic [3:0] rp;
      logic       any;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic r, input logic [3:0] e,
                      input logic [3:0] t, input logic [3:0] tp,
                      input logic [3:0] rp, input logic an);
      vec_t v;
      v.rst = r; v.ena = e; v.trig = t; v.tp = tp; v.rp = rp; v.any = an;
      tv.push_back(v);
   endtask

   task automatic clr_seq(input bit use_rst);
      string nm;
      nm = use_rst ? "rst" : "clr";
      ia.ena = 4'h0; tick();
      ia.ena = 4'h1; tick(); tick();
      ia.ena = 4'h3; tick(); tick();
      chk({nm, ".pre_trig"}, ia.trigger, 4'h1);
      if (use_rst) rst_n = 1'b0;
      else ia.clr = 1'b1;
      tick();
      chk({nm, ".trig"}, ia.trigger, 4'h0);
      chk({nm, ".rel"}, ia.rel_pulse, 4'h0);
      chk({nm, ".any"}, {3'b0, ia.any_trigger}, 4'h0);
      rst_n = 1'b1; ia.clr = 1'b0; ia.ena = 4'h2;
      tick(); tick(); tick();
      chk({nm, ".run3"}, ia.trigger, 4'h0);
      tick();
      chk({nm, ".run4"}, ia.trigger, 4'h2);
      chk({nm, ".run4_tp"}, ia.trig_pulse, 4'h2);
   endtask

   initial begin
      logic [5:0] pat;
      logic [3:0] e;
      rst_n = 1'b0;
      ia.clr = 1'b0; ib.clr = 1'b0; ic.clr = 1'b0;
      ia.ena = 4'h0; ib.ena = 4'h0; ic.ena = 4'h0;

      // reset with ena high, then channel 0 assert
      add(0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
      add(0, 4'hF, 4'h0, 4'h0, 4'h0, 0);
      add(1, 4'h1, 4'h0, 4'h0, 4'h0, 0);
      add(1, 4'h1, 4'h0, 4'h0, 4'h0, 0);
      add(1, 4'h1, 4'h0, 4'h0, 4'h0, 0);
      add(1, 4'h1, 4'h1, 4'h1, 4'h0, 1);
      add(1, 4'h1, 4'h1, 4'h0, 4'h0, 1);
      // broken run on channel 1: 1,1,1,0,1,1,1,1
      add(1, 4'h3, 4'h1, 4'h0, 4'h0, 1);
      add(1, 4'h3, 4'h1, 4'h0, 4'h0, 1);
      add(1, 4'h3, 4'h1, 4'h0, 4'h0, 1);
      add(1, 4'h1, 4'h1, 4'h0, 4'h0, 1);
      add(1, 4'h3, 4'h1, 4'h0, 4'h0, 1);
      add(1, 4'h3, 4'h1, 4'h0, 4'h0, 1);
      add(1, 4'h3, 4'h1, 4'h0, 4'h0, 1);
      add(1, 4'h3, 4'h3, 4'h2, 4'h0, 1);
      add(1, 4'h0, 4'h0, 4'h0, 4'h3, 0);
      add(1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
      // simultaneous channels 0 and 3
      add(1, 4'h9, 4'h0, 4'h0, 4'h0, 0);
      add(1, 4'h9, 4'h0, 4'h0, 4'h0, 0);
      add(1, 4'h9, 4'h0, 4'h0, 4'h0, 0);
      add(1, 4'h9, 4'h9, 4'h9, 4'h0, 1);
      add(1, 4'h0, 4'h0, 4'h0, 4'h9, 0);

      foreach (tv[i]) begin
         rst_n  = tv[i].rst;
         ia.ena = tv[i].ena;
         tick();
         chk("vec.trigger", ia.trigger, tv[i].trig);
         chk("vec.trig_pulse", ia.trig_pulse, tv[i].tp);
         chk("vec.rel_pulse", ia.rel_pulse, tv[i].rp);
         chk("vec.any", {3'b0, ia.any_trigger}, {3'b0, tv[i].any});
      end

      clr_seq(1'b0);
      clr_seq(1'b1);
      ia.ena = 4'h0;

      // hysteresis ON=3 OFF=3 on channel 2
      ib.ena = 4'h4;
      tick(); tick(); tick();
      chk("hyst.act", ib.trigger, 4'h4);
      chk("hyst.act_tp", ib.trig_pulse, 4'h4);
      pat = 6'b000100;
      for (int k = 0; k < 6; k++) begin
         ib.ena = pat[k] ? 4'h4 : 4'h0;
         tick();
         if (k < 5) begin
            chk("hyst.hold", ib.trigger, 4'h4);
            chk("hyst.hold_rp", ib.rel_pulse, 4'h0);
         end else begin
            chk("hyst.fall", ib.trigger, 4'h0);
            chk("hyst.fall_rp", ib.rel_pulse, 4'h4);
         end
      end
      tick();
      chk("hyst.rp_once", ib.rel_pulse, 4'h0);

      // ON=1 OFF=1 toggling follows ena one cycle late
      for (int k = 0; k < 4; k++) begin
         e = (k % 2 == 0) ? 4'h1 : 4'h0;
         ic.ena = e;
         tick();
         chk("deg.trigger", ic.trigger, e);
         chk("deg.trig_pulse", ic.trig_pulse, e);
         chk("deg.rel_pulse", ic.rel_pulse, ~e & 4'h1);
      end
      ic.ena = 4'h0;
      tick();

      // random traffic, occasional clear and reset
      for (int n = 0; n < 600; n++) begin
         ia.ena = ~(4'($urandom) & 4'($urandom));
         ib.ena = 4'($urandom);
         ic.ena = 4'($urandom);
         ia.clr = ($urandom_range(0, 39) == 0);
         ib.clr = ($urandom_range(0, 39) == 0);
         ic.clr = ($urandom_range(0, 39) == 0);
         rst_n  = ($urandom_range(0, 99) != 0);
         tick();
      end

      rst_n = 1'b1;
      ia.clr = 1'b0; ib.clr = 1'b0; ic.clr = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/persist_trigger.md
# persist_trigger

Multi-channel persistence detector with hysteresis: each channel's trigger asserts only after its enable input has been sampled high on ON_CNT consecutive clock edges. It deasserts only after the input has been sampled low on OFF_CNT consecutive edges. This block generalises the fixed 4-stage enable-chain trigger to CH independent channels with programmable assert and release depths, plus rise and fall event pulses. It sits between raw qualifying strobes and the control logic that consumes debounced triggers.

## Interface
- CH, 4: number of independent channels, ≥1.
- ON_CNT, 4: consecutive high samples required to assert, ≥1.
- OFF_CNT, 1: consecutive low samples required to deassert, ≥1.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- clr  in  1  synchronous clear of all channels; same effect as reset.
- ena  in  CH  per-channel raw enable, sampled each rising edge.
- trigger  out  CH  per-channel debounced level.
- trig_pulse  out  CH  one-cycle pulse when trigger[i] rises.
- rel_pulse  out  CH  one-cycle pulse when trigger[i] falls.
- any_trigger  out  1  OR of trigger, registered with the same timing as trigger.

## Operation
- Per-channel state: IDLE (trigger=0) or ACTIVE (trigger=1), plus a run counter cnt.
- cnt width is clog2(max(ON_CNT,OFF_CNT))+1. cnt never exceeds max−1, so no wrap is possible.
- IDLE:
  - ena[i]=1 and cnt==ON_CNT−1: go to ACTIVE, cnt←0, trig_pulse[i]←1.
  - ena[i]=1 otherwise: cnt←cnt+1.
  - ena[i]=0: cnt←0. A broken run restarts from zero.
- ACTIVE:
  - ena[i]=0 and cnt==OFF_CNT−1: go to IDLE, cnt←0, rel_pulse[i]←1.
  - ena[i]=0 otherwise: cnt←cnt+1.
  - ena[i]=1: cnt←0. A broken low-run restarts from zero.
- Pulses are registered. They are high for exactly the one cycle in which trigger first shows its new value, and are 0 in all other cycles.
- ON_CNT=1: IDLE→ACTIVE on the first high sample. OFF_CNT=1: ACTIVE→IDLE on the first low sample.
- Channels are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.
- Priority: rst_n low > clr high > normal update.
  - Either reset or clear forces all channels to IDLE, cnt=0, and all outputs to 0 at the next edge.
  - Reset or clear does not generate rel_pulse, even if a channel was ACTIVE.
- Reset or clear mid-run discards partial counts. After release, a full ON_CNT run is required again.

## Timing
- Reset values (state at the first edge with rst_n=0): trigger=0, trig_pulse=0, rel_pulse=0, any_trigger=0, all cnt=0.
- Assert latency: ena[i] high at edges k..k+ON_CNT−1 gives trigger[i]=1 and trig_pulse[i]=1 immediately after edge k+ON_CNT−1.
- With ON_CNT=4 and OFF_CNT=1, behaviour is cycle-identical to the legacy 4-flop chain.
- Release latency: ena[i] low at edges m..m+OFF_CNT−1 gives trigger[i]=0 and rel_pulse[i]=1 immediately after edge m+OFF_CNT−1.
- No combinational path from any input to any output; all outputs come directly from flops.
- clr and ena are sampled on the same edge; clr wins.

## Test plan
- Reset with defaults (CH=4, ON=4, OFF=1):
  - Drive rst_n=0 for 2 cycles with ena=4'hF → all outputs 0.
  - Release rst_n, hold ena[0]=1 → trigger[0] rises after the 4th edge; trig_pulse[0] high for one cycle; any_trigger=1 in that same cycle.
- Broken run, ON=4:
  - ena[1] pattern 1,1,1,0,1,1,1,1 → no trigger until after the 8th edge.
  - trig_pulse[1] fires exactly once.
- Hysteresis, ON=3, OFF=3, channel 2 already ACTIVE:
  - ena[2] pattern 0,0,1,0,0,0 → trigger stays 1 through the 5th edge, falls after the 6th edge.
  - rel_pulse[2] is a single cycle at that fall.
- Simultaneous channels:
  - ena[0] and ena[3] rise on the same edge → trigger[0], trigger[3] and both trig_pulse bits assert in the same cycle.
  - trigger[1] and trigger[2] remain 0.
- Clear and reset mid-operation:
  - clr=1 while trigger[0]=1 and channel 1 at cnt=2 → next cycle all trigger=0, no rel_pulse.
  - Channel 1 then needs a full 4-sample run to assert.
  - Repeat using rst_n=0 held for one edge → identical result.
- Degenerate depths, ON=1, OFF=1:
  - ena[0] toggling 1,0,1,0 → trigger[0] follows ena[0] delayed one cycle.
  - trig_pulse and rel_pulse alternate every cycle.
